// File: rtl/imem_prog_loader.sv
// Boot-time program loader: parses a length-prefixed, XOR-checksummed byte stream
// into big-endian 16-bit words and holds the processor until the image verifies.
module imem_prog_loader #(
  parameter int PROG_CTR_WID = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic                    imem_wr_en,
  output logic [PROG_CTR_WID-1:0] imem_wr_addr,
  output logic [15:0]             imem_wr_data,
  output logic                    cpu_hold,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [PROG_CTR_WID:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [16:0] CAP = 17'(1) << PROG_CTR_WID;

  state_e                  state_q, state_d;
  logic [7:0]              len_hi_q, len_hi_d;
  logic [PROG_CTR_WID:0]   len_q, len_d;
  logic [7:0]              hi_q, hi_d;
  logic [7:0]              sum_q, sum_d;
  logic                    wr_en_q, wr_en_d;
  logic [PROG_CTR_WID-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]             wr_data_q, wr_data_d;
  logic [PROG_CTR_WID:0]   cnt_q, cnt_d;
  logic                    hold_q, hold_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic                    accept;
  logic [16:0]             n_full;
  logic [PROG_CTR_WID:0]   cnt_inc;

  assign in_ready = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                    (state_q == S_CHECK);
  assign accept   = in_ready && in_valid;
  assign n_full   = {1'b0, len_hi_q, in_data};
  assign cnt_inc  = cnt_q + (PROG_CTR_WID+1)'(1);

  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    len_d     = len_q;
    hi_d      = hi_q;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          sum_d   = '0;
          cnt_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = in_data;
          sum_d    = sum_q ^ in_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          sum_d = sum_q ^ in_data;
          if (n_full > CAP) begin
            state_d = S_ERROR;
          end else begin
            len_d   = n_full[PROG_CTR_WID:0];
            state_d = (n_full == '0) ? S_CHECK : S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = in_data;
          sum_d   = sum_q ^ in_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          sum_d     = sum_q ^ in_data;
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[PROG_CTR_WID-1:0];
          wr_data_d = {hi_q, in_data};
          cnt_d     = cnt_inc;
          state_d   = (cnt_inc == len_q) ? S_CHECK : S_DATA_HI;
        end
      end
      S_CHECK: begin
        if (accept) begin
          state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status levels are registered from the next state so they line up with it.
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
    hold_d  = (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      len_hi_q  <= '0;
      len_q     <= '0;
      hi_q      <= '0;
      sum_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
      hold_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      len_q     <= len_d;
      hi_q      <= hi_d;
      sum_q     <= sum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign imem_wr_en   = wr_en_q;
  assign imem_wr_addr = wr_addr_q;
  assign imem_wr_data = wr_data_q;
  assign words_loaded = cnt_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Bench for imem_prog_loader: byte-index stream model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_imem_prog_loader;

  localparam int W   = 10;
  localparam int CAP = 1 << W;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready;
  logic         imem_wr_en;
  logic [W-1:0] imem_wr_addr;
  logic [15:0]  imem_wr_data;
  logic         cpu_hold;
  logic         busy;
  logic         done;
  logic         error;
  logic [W:0]   words_loaded;

  imem_prog_loader #(.PROG_CTR_WID(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: tracks position within the image by byte index.
  bit         m_active = 0;
  int         m_idx = 0;
  int         m_n = 0;
  logic [7:0] m_nhi = 0;
  logic [7:0] m_sum = 0;
  logic [7:0] m_hi = 0;
  int         m_cnt = 0;
  bit         m_wr_en = 0;
  int         m_addr = 0;
  logic [15:0] m_data = 0;
  bit         m_done = 0;
  bit         m_err = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 0; m_idx = 0; m_n = 0; m_sum = 0; m_cnt = 0;
      m_wr_en = 0; m_addr = 0; m_data = 0; m_done = 0; m_err = 0;
    end else begin
      m_wr_en = 0;
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_idx = 0; m_sum = 0; m_cnt = 0; m_done = 0; m_err = 0;
        end
      end else if (in_valid) begin
        if (m_idx == 0) begin
          m_nhi = in_data;
          m_sum = m_sum ^ in_data;
        end else if (m_idx == 1) begin
          m_n   = {m_nhi, in_data};
          m_sum = m_sum ^ in_data;
          if (m_n > CAP) begin
            m_active = 0;
            m_err    = 1;
          end
        end else if (m_idx < 2 + 2 * m_n) begin
          m_sum = m_sum ^ in_data;
          if (m_idx % 2 == 0) begin
            m_hi = in_data;
          end else begin
            m_wr_en = 1;
            m_addr  = m_cnt;
            m_data  = {m_hi, in_data};
            m_cnt++;
          end
        end else begin
          m_active = 0;
          if (in_data == m_sum) m_done = 1;
          else m_err = 1;
        end
        m_idx++;
      end
    end
  end

  logic [31:0] wlog[$];

  always @(negedge clk) begin
    if (reset) begin
      chk("in_ready", in_ready, m_active);
      chk("busy", busy, m_active);
      chk("imem_wr_en", imem_wr_en, m_wr_en);
      if (m_wr_en) begin
        chk("imem_wr_addr", imem_wr_addr, m_addr);
        chk("imem_wr_data", imem_wr_data, m_data);
      end
      chk("done", done, m_done);
      chk("error", error, m_err);
      chk("cpu_hold", cpu_hold, !m_done);
      chk("words_loaded", words_loaded, m_cnt);
      if (imem_wr_en) wlog.push_back({6'b0, imem_wr_addr, imem_wr_data});
    end
  end

  logic [7:0] strm[$];

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 259 + 4951);
  endfunction

  task automatic build(input int n, input bit nominal, input bit corrupt);
    logic [7:0] s;
    logic [15:0] w;
    strm.delete();
    strm.push_back(8'(n >> 8));
    strm.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      if (nominal) w = (i == 0) ? 16'h1234 : 16'hABCD;
      else w = pat(i);
      strm.push_back(w[15:8]);
      strm.push_back(w[7:0]);
    end
    s = 8'h00;
    foreach (strm[k]) s = s ^ strm[k];
    strm.push_back(corrupt ? (s ^ 8'h01) : s);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic r;
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      if (r) begin
        ok = 1;
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: byte 0x%0h never accepted, expected acceptance", b);
    end
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_range(input int from, input int to, input int gap);
    for (int k = from; k < to; k++) send_byte(strm[k], gap);
  endtask

  task automatic pulse_start(input bit with_byte);
    start = 1'b1;
    if (with_byte) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic chk_nominal_writes(input string tag);
    chk({tag, "_nwrites"}, wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk({tag, "_w0"}, wlog[0], {6'b0, 10'd0, 16'h1234});
      chk({tag, "_w1"}, wlog[1], {6'b0, 10'd1, 16'hABCD});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_wr_en", imem_wr_en, 0);
    chk("rst_wr_addr", imem_wr_addr, 0);
    chk("rst_wr_data", imem_wr_data, 0);
    chk("rst_words", words_loaded, 0);
    @(posedge clk); #1;

    // Nominal back-to-back load.
    wlog.delete();
    pulse_start(0);
    build(2, 1, 0);
    chk("nom_checksum_byte", strm[6], 8'h42);
    send_range(0, strm.size(), 0);
    @(negedge clk);
    chk("nom_done", done, 1);
    chk("nom_hold", cpu_hold, 0);
    chk("nom_words", words_loaded, 2);
    chk("nom_model_cnt", m_cnt, 2);
    chk_nominal_writes("nom");
    @(posedge clk); #1;

    // Empty image; start coincides with a byte that must not be consumed.
    wlog.delete();
    pulse_start(1);
    @(negedge clk);
    chk("restart_hold", cpu_hold, 1);
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    @(posedge clk); #1;
    build(0, 1, 0);
    send_range(0, strm.size(), 0);
    @(negedge clk);
    chk("empty_done", done, 1);
    chk("empty_hold", cpu_hold, 0);
    chk("empty_nwrites", wlog.size(), 0);
    @(posedge clk); #1;

    // Bad checksum, then a correct retry.
    wlog.delete();
    pulse_start(0);
    build(2, 1, 1);
    send_range(0, strm.size(), 0);
    @(negedge clk);
    chk("bad_error", error, 1);
    chk("bad_done", done, 0);
    chk("bad_hold", cpu_hold, 1);
    chk_nominal_writes("bad");
    @(posedge clk); #1;
    wlog.delete();
    pulse_start(0);
    build(2, 1, 0);
    send_range(0, strm.size(), 0);
    @(negedge clk);
    chk("retry_done", done, 1);
    chk("retry_error", error, 0);
    @(posedge clk); #1;

    // Backpressure with a start pulse that must be ignored mid-load.
    wlog.delete();
    pulse_start(0);
    build(2, 1, 0);
    send_range(0, 1, 0);
    pulse_start(0);
    send_range(1, strm.size(), 3);
    @(negedge clk);
    chk("bp_done", done, 1);
    chk("bp_words", words_loaded, 2);
    chk_nominal_writes("bp");
    @(posedge clk); #1;

    // Oversize length rejected.
    wlog.delete();
    pulse_start(0);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    chk("over_error", error, 1);
    chk("over_ready", in_ready, 0);
    chk("over_nwrites", wlog.size(), 0);
    @(posedge clk); #1;

    // Maximum length image fills every address with no wrap.
    wlog.delete();
    pulse_start(0);
    build(CAP, 0, 0);
    send_range(0, 2, 0);
    @(negedge clk);
    chk("max_ready", in_ready, 1);
    chk("max_busy", busy, 1);
    chk("max_error", error, 0);
    @(posedge clk); #1;
    send_range(2, strm.size(), 0);
    @(negedge clk);
    chk("max_done", done, 1);
    chk("max_words", words_loaded, CAP);
    chk("max_nwrites", wlog.size(), CAP);
    if (wlog.size() == CAP) begin
      chk("max_first", wlog[0], {6'b0, 10'd0, pat(0)});
      chk("max_last", wlog[CAP-1], {6'b0, 10'h3FF, pat(CAP-1)});
    end
    @(posedge clk); #1;

    // Reset right after the low byte of word 0 is accepted.
    wlog.delete();
    pulse_start(0);
    build(2, 1, 0);
    send_range(0, 4, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_wr_en", imem_wr_en, 0);
    chk("mr_hold", cpu_hold, 1);
    chk("mr_ready", in_ready, 0);
    chk("mr_busy", busy, 0);
    chk("mr_words", words_loaded, 0);
    chk("mr_addr", imem_wr_addr, 0);
    chk("mr_data", imem_wr_data, 0);
    chk("mr_done", done, 0);
    chk("mr_error", error, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("mr_nwrites", wlog.size(), 0);
    chk("mr_idle_hold", cpu_hold, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_prog_loader.md
# imem_prog_loader

Boot-time program loader that sits directly upstream of the processor top level. It accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instructions. It writes them sequentially into instruction memory starting at address 0 and holds the processor in reset until a complete, checksum-verified image has been loaded.

## Interface
Parameters:
- PROG_CTR_WID, 10, instruction memory address width; capacity is 2^PROG_CTR_WID words.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- in_valid  in  1  byte stream valid.
- in_data  in  8  byte stream data.
- in_ready  out  1  loader can accept a byte.
- imem_wr_en  out  1  instruction memory write strobe, one cycle per word.
- imem_wr_addr  out  PROG_CTR_WID  word address being written.
- imem_wr_data  out  16  instruction word, {high byte, low byte}.
- cpu_hold  out  1  active-high processor reset request.
- busy  out  1  load in progress.
- done  out  1  image loaded and verified (level).
- error  out  1  load failed (level).
- words_loaded  out  PROG_CTR_WID+1  count of words written in the current load.

## Operation
- Stream format:
  - Byte 0: length high byte; byte 1: length low byte. The length N is a word count.
  - Next 2N bytes: instruction words, high byte first.
  - Final byte: checksum, equal to the XOR of every preceding byte, length bytes included.
- A byte is accepted on a rising clk edge when in_valid and in_ready are both 1. in_data is ignored otherwise.
- States:
  - IDLE -> LEN_HI on start.
  - LEN_HI -> LEN_LO on accept.
  - LEN_LO, on accept:
    - N > 2^PROG_CTR_WID -> ERROR.
    - N = 0 -> CHECK.
    - otherwise -> DATA_HI.
  - DATA_HI -> DATA_LO on accept; the high byte is latched.
  - DATA_LO, on accept: issue a write. Go to CHECK if this was word N, otherwise back to DATA_HI.
  - CHECK, on accept: byte equals the running XOR -> DONE, otherwise -> ERROR.
  - DONE / ERROR -> LEN_HI on start, which clears done, error, words_loaded and the running XOR.
- in_ready = 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; 0 in IDLE, DONE and ERROR.
- busy = 1 in the same states as in_ready.
- start is ignored while busy.
- Addressing:
  - imem_wr_addr = words_loaded[PROG_CTR_WID-1:0] at the time of the write.
  - words_loaded increments with each write.
  - N = 2^PROG_CTR_WID is legal; the last address is all-ones and no wrap occurs.
- cpu_hold:
  - 1 from reset, and in every state except DONE.
  - Re-asserts the cycle after a new start is accepted from DONE.
- error is sticky until the next start or reset. Memory contents written before an error are left in place; the processor stays held.

## Timing
- All outputs are registered except in_ready, which decodes the current state.
- Reset values:
  - state IDLE, in_ready 0, busy 0, done 0, error 0.
  - cpu_hold 1.
  - imem_wr_en 0, imem_wr_addr 0, imem_wr_data 0, words_loaded 0.
  - Running XOR 0.
- Write timing:
  - imem_wr_en is high for exactly one cycle, in the cycle after the low byte is accepted.
  - imem_wr_addr and imem_wr_data are valid in that same cycle.
  - words_loaded shows the new count in that same cycle.
- Latency and throughput:
  - Back-to-back accepts are supported at one byte per cycle; minimum spacing between writes is 2 cycles.
  - Gaps in in_valid stall the FSM in its current state with no side effects.
- Completion: done = 1 and cpu_hold = 0 in the cycle after the checksum byte is accepted. error = 1 in the cycle after the failing byte.
- start in the same cycle as a byte: in IDLE/DONE/ERROR in_ready is 0, so the byte is not consumed. Busy states ignore start.
- Reset asserted mid-load: every output returns to its reset value asynchronously, and any pending write is dropped. No write strobe may glitch out on the reset edge.

## Test plan
- Reset: hold reset=0 for 3 cycles, then release -> cpu_hold=1, in_ready=0, done=0, error=0, imem_wr_en=0, words_loaded=0.
- Nominal load: start, then stream 00 02 12 34 AB CD 42 back-to-back.
  - Writes: (addr 0, 0x1234) and (addr 1, 0xABCD), each a single-cycle strobe.
  - done=1 and cpu_hold=0 in the cycle after 0x42; words_loaded=2.
- Empty image: start, then 00 00 00 -> no writes; done=1, cpu_hold=0.
- Bad checksum: the nominal stream with a final byte of 0x43 -> both writes occur; error=1, done=0, cpu_hold=1.
  - A following start plus the correct nominal stream -> done=1.
- Oversize image (PROG_CTR_WID=10): start, then 04 01 -> error=1 after the second byte, no writes.
  - Length 04 00 is accepted and enters DATA_HI.
- Backpressure and mid-load reset:
  - Nominal stream with in_valid deasserted for 3 cycles between every byte -> identical writes and result to the back-to-back case.
  - Separate run: assert reset after byte 0x34 is accepted -> no write for word 0; all outputs at reset values; cpu_hold=1.
